shift_r: RTL and testbench
==========================

// Module: shift_r
// PURPOSE
//  Delay line (tap memory) for the FIR datapath: holds the last DEPTH input samples.
//  A new sample is pushed in on request; older samples move one slot deeper.
//  The MAC sequencer reads any slot by address.
//  Slot 0 = newest sample, slot DEPTH-1 = oldest.
// PARAMETERS
//  DATA_W  16  sample width in bits (two's-complement, treated as opaque bits)
//  DEPTH   32  number of stored samples / FIR taps
//  ADDR_W  5   read address width, >= clog2(DEPTH)
// PORTS
//  clk          in   1       system clock, all state updates on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  probka_in    in   DATA_W  incoming sample, captured when nowa_shift=1
//  nowa_shift   in   1       push strobe: shift line, store probka_in in slot 0
//  reset_shift  in   1       synchronous clear of all slots
//  adres        in   ADDR_W  read address (slot index)
//  out          out  DATA_W  content of slot adres
// BEHAVIOUR
//  - rst_n=0: all slots cleared to 0 immediately, regardless of clk; out=0.
//  - Rising clk edge, priority order:
//      1. reset_shift=1: all slots <= 0. Any simultaneous nowa_shift is ignored.
//      2. nowa_shift=1: mem[0] <= probka_in; mem[i] <= mem[i-1] for i=1..DEPTH-1.
//         Old mem[DEPTH-1] is discarded.
//      3. Otherwise: hold.
//  - nowa_shift is level-sensitive: held high for N cycles gives N shifts,
//    one per cycle, sampling probka_in each cycle.
//  - Read path is combinational: out = mem[adres], zero latency.
//    A push at edge k is visible at out right after edge k.
//  - adres >= DEPTH (only possible when DEPTH < 2**ADDR_W): out = 0.
//  - Reads never modify state; adres may change every cycle.
//  - Initial content after any reset is all-zero, so taps not yet filled
//    contribute 0 to the FIR sum.
// CONFIGURATION
//  SHIFT_R_REG_OUT_EN defined:
//    - out is a register loaded each rising edge with the value the
//      combinational path would show; 1-cycle read latency.
//    - Register cleared by rst_n and by reset_shift.
//    - On a push edge, the register captures the pre-shift content.
//  SHIFT_R_REG_OUT_EN undefined: combinational read as above (default).
// TESTING (default build, DEPTH=32)
//  - rst_n=0 then 1 -> out=0 for adres 0..31.
//  - probka_in=5, 1 cycle nowa_shift -> adres0=5; adres1=0; adres2=0.
//  - Then probka_in=10 pushed -> adres0=10; adres1=5; adres2=0.
//  - 32 consecutive pushes of 0,2,4..62 (nowa_shift held high) -> adres i = 62-2*i
//    (adres0=62, adres31=0); earlier 5 and 10 are gone.
//  - reset_shift=1 together with nowa_shift=1, probka_in=7 -> all slots 0 next cycle.
//  - rst_n asserted mid-clock-period with data loaded -> out=0 before next edge.
//  - With SHIFT_R_REG_OUT_EN: push 5, set adres=0 -> out=5 one cycle later.

Source files
------------

// File: rtl/shift_r.sv
// shift_r: DEPTH-slot sample delay line (slot 0 newest) with an addressed read port for the FIR MAC.
// Define SHIFT_R_REG_OUT_EN to register the read port (1-cycle read latency).

module shift_r_slot #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);
   // clr wins over en so a clear on a push edge drops the incoming sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= '0;
      else if (clr) q <= '0;
      else if (en)  q <= d;
   end
endmodule

module shift_r #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] probka_in,
   input  logic              nowa_shift,
   input  logic              reset_shift,
   input  logic [ADDR_W-1:0] adres,
   output logic [DATA_W-1:0] out
);
   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [DATA_W-1:0]            rd_data;

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      logic [DATA_W-1:0] d;
      if (g == 0) begin : g_head
         assign d = probka_in;
      end else begin : g_tail
         assign d = mem[g-1];
      end
      shift_r_slot #(.DATA_W(DATA_W)) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (reset_shift),
         .en    (nowa_shift),
         .d     (d),
         .q     (mem[g])
      );
   end

   // Address decode instead of mem[adres] so addresses past DEPTH read as zero
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < DEPTH; i++)
         if (adres == ADDR_W'(i)) rd_data = mem[i];
   end

`ifdef SHIFT_R_REG_OUT_EN
   // rd_data reflects pre-edge content, so a push edge captures the pre-shift slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           out <= '0;
      else if (reset_shift) out <= '0;
      else                  out <= rd_data;
   end
`else
   assign out = rd_data;
`endif

endmodule

// File: tb/tb_shift_r.sv
// Randomized self-checking bench for shift_r (default combinational-read build).
module tb_shift_r;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] probka_in = '0;
   logic              nowa_shift = 1'b0;
   logic              reset_shift = 1'b0;
   logic [ADDR_W-1:0] adres = '0;
   logic [DATA_W-1:0] out;

   int vectors = 0;
   int errors  = 0;

   // Reference: queue with newest sample at the front, always DEPTH long
   logic [DATA_W-1:0] model[$];

   shift_r #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .probka_in   (probka_in),
      .nowa_shift  (nowa_shift),
      .reset_shift (reset_shift),
      .adres       (adres),
      .out         (out)
   );

   always #5 clk = ~clk;

   function automatic void model_clear();
      model.delete();
      for (int i = 0; i < DEPTH; i++) model.push_back('0);
   endfunction

   function automatic logic [DATA_W-1:0] model_read(int a);
      return (a < DEPTH) ? model[a] : '0;
   endfunction

   // Drive one edge's inputs, apply the edge, update the model; inputs stay as driven
   task automatic cycle(input logic push, input logic rs, input logic [DATA_W-1:0] d);
      nowa_shift  = push;
      reset_shift = rs;
      probka_in   = d;
      @(posedge clk);
      if (rs) model_clear();
      else if (push) begin
         model.push_front(d);
         void'(model.pop_back());
      end
      #1;
   endtask

   task automatic idle();
      nowa_shift  = 1'b0;
      reset_shift = 1'b0;
   endtask

   task automatic test_reset();
      logic [DATA_W-1:0] exp;
      idle();
      rst_n = 1'b0;
      model_clear();
      #12;
      rst_n = 1'b1;
      #3;
      for (int i = 0; i < DEPTH; i++) begin
         adres = ADDR_W'(i);
         #1;
         exp = model_read(i);
         vectors++;
         if (out !== exp) begin
            errors++;
            $display("FAIL reset adres=%0d out=%0h exp=%0h", i, out, exp);
         end
      end
   endtask

   task automatic test_basic();
      logic [DATA_W-1:0] exp;
      cycle(1'b1, 1'b0, 16'd5);
      idle();
      for (int i = 0; i < 3; i++) begin
         adres = ADDR_W'(i);
         #1;
         exp = (i == 0) ? 16'd5 : 16'd0;
         vectors++;
         if (out !== exp) begin
            errors++;
            $display("FAIL push5 adres=%0d out=%0h exp=%0h", i, out, exp);
         end
      end
      cycle(1'b1, 1'b0, 16'd10);
      idle();
      for (int i = 0; i < 3; i++) begin
         adres = ADDR_W'(i);
         #1;
         exp = (i == 0) ? 16'd10 : (i == 1) ? 16'd5 : 16'd0;
         vectors++;
         if (out !== exp) begin
            errors++;
            $display("FAIL push10 adres=%0d out=%0h exp=%0h", i, out, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] exp;
      for (int k = 0; k < DEPTH; k++) cycle(1'b1, 1'b0, DATA_W'(2 * k));
      idle();
      for (int i = 0; i < DEPTH; i++) begin
         adres = ADDR_W'(i);
         #1;
         exp = DATA_W'(62 - 2 * i);
         vectors++;
         if (out !== exp || model_read(i) !== exp) begin
            errors++;
            $display("FAIL fill adres=%0d out=%0h exp=%0h", i, out, exp);
         end
      end
   endtask

   task automatic test_clear_priority();
      cycle(1'b1, 1'b1, 16'd7);
      idle();
      for (int i = 0; i < DEPTH; i++) begin
         adres = ADDR_W'(i);
         #1;
         vectors++;
         if (out !== 16'd0) begin
            errors++;
            $display("FAIL clr_prio adres=%0d out=%0h exp=0", i, out);
         end
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] exp;
      int a;
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0, DATA_W'($urandom));
         for (int r = 0; r < 2; r++) begin
            a = $urandom_range(0, DEPTH - 1);
            adres = ADDR_W'(a);
            #1;
            exp = model_read(a);
            vectors++;
            if (out !== exp) begin
               errors++;
               $display("FAIL random n=%0d adres=%0d out=%0h exp=%0h", n, a, out, exp);
            end
         end
      end
      idle();
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, DATA_W'(16'h1234 + k));
      idle();
      adres = '0;
      #1;
      vectors++;
      if (out !== 16'h1237) begin
         errors++;
         $display("FAIL preload out=%0h exp=1237", out);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      for (int i = 0; i < 4; i++) begin
         adres = ADDR_W'(i);
         #0.5;
         vectors++;
         if (out !== 16'd0) begin
            errors++;
            $display("FAIL async_rst adres=%0d out=%0h exp=0", i, out);
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      fork
         begin
            #200000;
            errors++;
            $display("FAIL timeout");
            $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
            $fatal(1, "timeout");
         end
      join_none
      model_clear();
      test_reset();
      test_basic();
      test_back_to_back();
      test_clear_priority();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
